// File: rtl/me_ctrl_pkg.sv
// Shared definitions for the motion-estimation run controller: FSM state
// encoding, push-button indices and history-entry field widths.
package me_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int BTN_START = 0;
    localparam int BTN_ABORT = 1;
    localparam int BTN_THR   = 2;
    localparam int BTN_VIEW  = 3;
    localparam int NUM_BTN   = 4;

    // Run-length counter and stored cycle field share one width.
    localparam int RUN_CNT_W = 32;
    localparam int CYC_W     = 32;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: two-flop synchroniser, stability counter
// and a one-cycle press pulse on each debounced 1->0 transition of the
// active-low button. The pulse appears DEBOUNCE+3 cycles after a clean edge.
module btn_debounce #(
    parameter int DEBOUNCE = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    // Synchronise, accept a new level only after DEBOUNCE differing cycles, pulse on falling level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0  <= 1'b1;
            sync_p1  <= 1'b1;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync_p0  <= btn_n;
            sync_p1  <= sync_p0;
            stable_d <= stable;
            press    <= stable_d & ~stable;
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/me_run_ctrl.sv
// Board-side run controller for the ME core: debounced buttons drive a
// req/ack session, a steppable SAD threshold, a run timeout and a circular
// result history browsed by the 7-seg display through the view_* outputs.
// Optional feature macro: CYCLE_COUNT_EN (store and show run length per entry).
module me_run_ctrl
    import me_ctrl_pkg::*;
#(
    parameter int SAD_WIDTH = 16,
    parameter int CNT_WIDTH = 12,
    parameter int THR_MIN   = 1000,
    parameter int THR_MAX   = 8000,
    parameter int THR_STEP  = 1000,
    parameter int DEBOUNCE  = 65536,
    parameter int RES_DEPTH = 8,
    parameter int TIMEOUT   = 2**24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [3:0]                     btn_n,
    output logic                           req,
    output logic [SAD_WIDTH-1:0]           threshold,
    input  logic                           ack,
    input  logic [SAD_WIDTH-1:0]           min_sad,
    input  logic [CNT_WIDTH-1:0]           min_mvec,
    output logic                           busy,
    output logic                           timeout,
    output logic [$clog2(RES_DEPTH):0]     res_count,
    output logic [$clog2(RES_DEPTH)-1:0]   view_idx,
    output logic [SAD_WIDTH-1:0]           view_sad,
    output logic [CNT_WIDTH-1:0]           view_mvec,
    output logic [31:0]                    view_cyc
);

    localparam int IDX_W = $clog2(RES_DEPTH);

    // Threshold step with wrap back to the minimum once past the maximum.
    function automatic logic [SAD_WIDTH-1:0] thr_next(input logic [SAD_WIDTH-1:0] cur);
        logic [SAD_WIDTH:0] sum;
        sum = {1'b0, cur} + (SAD_WIDTH + 1)'(THR_STEP);
        if (sum > (SAD_WIDTH + 1)'(THR_MAX)) begin
            return SAD_WIDTH'(THR_MIN);
        end
        return sum[SAD_WIDTH-1:0];
    endfunction

    // Entry count saturating at the buffer depth.
    function automatic logic [IDX_W:0] count_sat(input logic [IDX_W:0] c);
        if (c == (IDX_W + 1)'(RES_DEPTH)) begin
            return c;
        end
        return c + (IDX_W + 1)'(1);
    endfunction

    // Browse index advance modulo the number of valid entries.
    function automatic logic [IDX_W-1:0] view_step(input logic [IDX_W-1:0] idx,
                                                   input logic [IDX_W:0]   c);
        logic [IDX_W:0] nx;
        nx = {1'b0, idx} + (IDX_W + 1)'(1);
        if (nx >= c) begin
            return '0;
        end
        return nx[IDX_W-1:0];
    endfunction

    logic [NUM_BTN-1:0]   press;
    state_t               state;
    logic [RUN_CNT_W-1:0] run_cnt;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_ptr;
    logic [IDX_W-1:0]     rd_ptr;
    logic [SAD_WIDTH-1:0] sad_mem  [RES_DEPTH];
    logic [CNT_WIDTH-1:0] mvec_mem [RES_DEPTH];

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE (DEBOUNCE)
            ) u_db (
                .clk   (clk),
                .rst   (rst),
                .btn_n (btn_n[g]),
                .press (press[g])
            );
        end
    endgenerate

    // A result is captured on the edge where ack is first seen in REQ.
    assign wr_en = (state == ST_REQ) && ack;

    // Newest entry sits just behind the write pointer; view_idx counts back from it.
    assign rd_ptr = wr_ptr - IDX_W'(1) - view_idx;

    // Session FSM with registered req/busy/timeout and the threshold register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req       <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            threshold <= SAD_WIDTH'(THR_MIN);
            run_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (press[BTN_THR]) begin
                        threshold <= thr_next(threshold);
                    end
                    // Abort in the same cycle suppresses a start; a start while the
                    // core still holds ack from a previous session is refused.
                    if (!press[BTN_ABORT] && press[BTN_START] && !ack) begin
                        state   <= ST_REQ;
                        req     <= 1'b1;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                        run_cnt <= '0;
                    end
                end
                ST_REQ: begin
                    run_cnt <= run_cnt + 1'b1;
                    if (ack) begin
                        state <= ST_DONE;
                        req   <= 1'b0;
                    end else if (press[BTN_ABORT] ||
                                 run_cnt == RUN_CNT_W'(TIMEOUT - 1)) begin
                        state <= ST_DRAIN;
                        req   <= 1'b0;
                        if (run_cnt == RUN_CNT_W'(TIMEOUT - 1)) begin
                            timeout <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_DRAIN: begin
                    if (!ack) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // History bookkeeping: write pointer, saturating count and browse index.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            res_count <= '0;
            view_idx  <= '0;
        end else if (wr_en) begin
            wr_ptr    <= wr_ptr + 1'b1;
            res_count <= count_sat(res_count);
            view_idx  <= '0;
        end else if (press[BTN_VIEW] && res_count != '0) begin
            view_idx  <= view_step(view_idx, res_count);
        end
    end

    // History storage; contents are meaningless until counted by res_count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            sad_mem[wr_ptr]  <= min_sad;
            mvec_mem[wr_ptr] <= min_mvec;
        end
    end

    // Registered view of the browsed entry, zero while the history is empty.
    always_ff @(posedge clk) begin
        if (res_count == '0) begin
            view_sad  <= '0;
            view_mvec <= '0;
        end else begin
            view_sad  <= sad_mem[rd_ptr];
            view_mvec <= mvec_mem[rd_ptr];
        end
    end

`ifdef CYCLE_COUNT_EN
    logic [CYC_W-1:0] cyc_mem [RES_DEPTH];

    // Run length counts edges from req rise up to and including the ack edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            cyc_mem[wr_ptr] <= run_cnt + 1'b1;
        end
    end

    // Registered run length of the browsed entry.
    always_ff @(posedge clk) begin
        if (res_count == '0) begin
            view_cyc <= '0;
        end else begin
            view_cyc <= cyc_mem[rd_ptr];
        end
    end
`else
    assign view_cyc = '0;
`endif

endmodule

// File: tb/tb_me_run_ctrl.sv
// Self-checking bench for me_run_ctrl with a scoreboard: stimulus pushes the
// expected threshold and run outcome, a monitor pops them on req edges.
module tb_me_run_ctrl;

    localparam int SW       = 16;
    localparam int CW       = 12;
    localparam int DEB      = 4;
    localparam int TO       = 64;
    localparam int D        = 4;
    localparam int THR_MIN  = 1000;
    localparam int THR_MAX  = 8000;
    localparam int THR_STEP = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    btn_n = 4'hF;
    logic          req;
    logic [SW-1:0] threshold;
    logic          ack = 1'b0;
    logic [SW-1:0] min_sad = '0;
    logic [CW-1:0] min_mvec = '0;
    logic          busy;
    logic          timeout;
    logic [2:0]    res_count;
    logic [1:0]    view_idx;
    logic [SW-1:0] view_sad;
    logic [CW-1:0] view_mvec;
    logic [31:0]   view_cyc;

    always #5 clk = ~clk;

    me_run_ctrl #(
        .SAD_WIDTH (SW),
        .CNT_WIDTH (CW),
        .THR_MIN   (THR_MIN),
        .THR_MAX   (THR_MAX),
        .THR_STEP  (THR_STEP),
        .DEBOUNCE  (DEB),
        .RES_DEPTH (D),
        .TIMEOUT   (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .req       (req),
        .threshold (threshold),
        .ack       (ack),
        .min_sad   (min_sad),
        .min_mvec  (min_mvec),
        .busy      (busy),
        .timeout   (timeout),
        .res_count (res_count),
        .view_idx  (view_idx),
        .view_sad  (view_sad),
        .view_mvec (view_mvec),
        .view_cyc  (view_cyc)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference model: newest-first history, threshold, browse index.
    int thr_m  = THR_MIN;
    int view_m = 0;
    int hist_sad[$];
    int hist_mvec[$];
    int hist_cyc[$];

    typedef struct {
        bit wr;
        bit to;
        int rc;
        int sad;
        int mvec;
        int cyc;
    } out_t;

    int   thr_q[$];
    out_t out_q[$];

    function automatic void model_write(int sad, int mvec, int cyc);
        hist_sad.push_front(sad);
        hist_mvec.push_front(mvec);
        hist_cyc.push_front(cyc);
        if (hist_sad.size() > D) begin
            void'(hist_sad.pop_back());
            void'(hist_mvec.pop_back());
            void'(hist_cyc.pop_back());
        end
        view_m = 0;
    endfunction

    // Monitor: req rise consumes a threshold expectation, req fall a run outcome.
    initial begin
        bit   req_p;
        int   t;
        out_t o;
        req_p = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_p = 1'b0;
            end else begin
                if (req && !req_p) begin
                    if (thr_q.size() == 0) begin
                        chk("unexpected_req", req, 0);
                    end else begin
                        t = thr_q.pop_front();
                        chk("req_threshold", threshold, t);
                        chk("req_timeout_clr", timeout, 0);
                        chk("req_busy", busy, 1);
                    end
                end
                if (!req && req_p) begin
                    if (out_q.size() == 0) begin
                        chk("unexpected_end", out_q.size(), 1);
                    end else begin
                        o = out_q.pop_front();
                        chk("end_timeout", timeout, o.to);
                        chk("end_res_count", res_count, o.rc);
                        if (o.wr) begin
                            @(negedge clk);
                            chk("wr_view_idx", view_idx, 0);
                            chk("wr_view_sad", view_sad, o.sad);
                            chk("wr_view_mvec", view_mvec, o.mvec);
`ifdef CYCLE_COUNT_EN
                            chk("wr_view_cyc", view_cyc, o.cyc);
`else
                            chk("wr_view_cyc", view_cyc, 0);
`endif
                        end
                    end
                end
                req_p = req;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req(input logic v, input int bound, input string name);
        int i = 0;
        while (req !== v && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk(name, req, v);
    endtask

    task automatic wait_idle(input int bound, input string name);
        int i = 0;
        while (busy !== 1'b0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        chk(name, busy, 0);
    endtask

    task automatic press_btn(input int b);
        btn_n[b] = 1'b0;
        idle(DEB + 6);
        btn_n[b] = 1'b1;
        idle(DEB + 6);
    endtask

    task automatic thr_step_idle();
        press_btn(2);
        thr_m = thr_m + THR_STEP;
        if (thr_m > THR_MAX) thr_m = THR_MIN;
        chk("threshold", threshold, thr_m);
    endtask

    // Press start (optionally bouncing) and check req appears DEB+4 cycles after the final edge.
    task automatic start_run(input bit bounce);
        int n = 0;
        thr_q.push_back(thr_m);
        btn_n[0] = 1'b0;
        if (bounce) begin
            idle(2);
            btn_n[0] = 1'b1;
            idle(1);
            btn_n[0] = 1'b0;
        end
        while (req !== 1'b1 && n < DEB + 12) begin
            @(negedge clk);
            n++;
        end
        chk("start_latency", n, DEB + 4);
        btn_n[0] = 1'b1;
    endtask

    // Core answers d cycles after req rose; result must land in history.
    task automatic finish_ack(input int d, input int sad, input int mvec);
        out_t o;
        model_write(sad, mvec, d);
        o.wr = 1'b1; o.to = 1'b0; o.rc = hist_sad.size();
        o.sad = sad; o.mvec = mvec; o.cyc = d;
        out_q.push_back(o);
        repeat (d - 1) @(negedge clk);
        ack = 1'b1;
        min_sad = SW'(sad);
        min_mvec = CW'(mvec);
        wait_req(1'b0, 4, "ack_req_drop");
        idle(2);
        chk("done_busy", busy, 1);
        ack = 1'b0;
        min_sad = SW'($urandom);
        min_mvec = CW'($urandom);
        wait_idle(4, "done_to_idle");
        idle(DEB + 6);
    endtask

    task automatic run_ack(input int d, input int sad, input int mvec);
        start_run(1'b0);
        finish_ack(d, sad, mvec);
    endtask

    task automatic run_timeout();
        out_t o;
        int n = 0;
        start_run(1'b0);
        o.wr = 1'b0; o.to = 1'b1; o.rc = hist_sad.size();
        o.sad = 0; o.mvec = 0; o.cyc = 0;
        out_q.push_back(o);
        while (req === 1'b1 && n < TO + 10) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_len", n, TO);
        wait_idle(4, "timeout_idle");
        idle(DEB + 6);
    endtask

    task automatic run_abort(input int d, input bit junk);
        out_t o;
        start_run(1'b0);
        o.wr = 1'b0; o.to = 1'b0; o.rc = hist_sad.size();
        o.sad = 0; o.mvec = 0; o.cyc = 0;
        out_q.push_back(o);
        idle(d);
        btn_n[1] = 1'b0;
        wait_req(1'b0, DEB + 8, "abort_drop");
        if (junk) begin
            ack = 1'b1;
            min_sad = SW'($urandom);
            min_mvec = CW'($urandom);
            idle(3);
            chk("drain_busy", busy, 1);
            ack = 1'b0;
        end
        wait_idle(4, "drain_idle");
        btn_n[1] = 1'b1;
        chk("drain_res_count", res_count, hist_sad.size());
        idle(DEB + 6);
    endtask

    task automatic view_next();
        int es, em, ec;
        press_btn(3);
        if (hist_sad.size() != 0) view_m = (view_m + 1) % hist_sad.size();
        es = 0; em = 0; ec = 0;
        if (hist_sad.size() != 0) begin
            es = hist_sad[view_m];
            em = hist_mvec[view_m];
            ec = hist_cyc[view_m];
        end
        chk("view_idx", view_idx, view_m);
        chk("view_sad", view_sad, es);
        chk("view_mvec", view_mvec, em);
`ifdef CYCLE_COUNT_EN
        chk("view_cyc", view_cyc, ec);
`else
        chk("view_cyc", view_cyc, 0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_threshold", threshold, THR_MIN);
        chk("rst_res_count", res_count, 0);
        chk("rst_view_idx", view_idx, 0);
        idle(1);
        chk("rst_view_sad", view_sad, 0);

        // Threshold walk through the full range and wrap.
        for (int i = 0; i < 8; i++) thr_step_idle();

        // Bounced start, then a result after 20 cycles.
        start_run(1'b1);
        finish_ack(20, 'h0123, 'h045);
        chk("first_res_count", res_count, 1);

        // Six results overflow the history; browse it including the wrap.
        for (int i = 1; i <= 6; i++) run_ack(2 + i, i, i * 16);
        chk("full_res_count", res_count, D);
        for (int i = 0; i < 5; i++) view_next();

        // Timeout leaves history intact; next start clears the flag.
        run_timeout();
        chk("timeout_sticky", timeout, 1);
        run_ack(5, 'h0abc, 'h0de);
        chk("timeout_cleared", timeout, 0);

        // Abort with results arriving during drain.
        run_abort(3, 1'b1);

        // Abort pulse and ack on the same REQ cycle: result kept.
        start_run(1'b0);
        btn_n[1] = 1'b0;
        begin
            out_t o;
            model_write('h0777, 'h077, DEB + 4);
            o.wr = 1'b1; o.to = 1'b0; o.rc = hist_sad.size();
            o.sad = 'h0777; o.mvec = 'h077; o.cyc = DEB + 4;
            out_q.push_back(o);
        end
        idle(DEB + 3);
        ack = 1'b1;
        min_sad = 'h0777;
        min_mvec = 'h077;
        wait_req(1'b0, 4, "race_req_drop");
        idle(2);
        ack = 1'b0;
        btn_n[1] = 1'b1;
        wait_idle(4, "race_idle");
        idle(DEB + 6);

        // Abort and start together in IDLE, and start while ack is high: no session.
        btn_n[0] = 1'b0;
        btn_n[1] = 1'b0;
        idle(DEB + 8);
        chk("abort_start_busy", busy, 0);
        btn_n[0] = 1'b1;
        btn_n[1] = 1'b1;
        idle(DEB + 6);
        ack = 1'b1;
        press_btn(0);
        chk("start_with_ack_busy", busy, 0);
        ack = 1'b0;
        idle(2);

        // Threshold step while busy is ignored.
        start_run(1'b0);
        press_btn(2);
        chk("thr_busy_unchanged", threshold, thr_m);
        finish_ack(3, 'h0042, 'h011);

        // Randomised mix of sessions and button activity.
        for (int i = 0; i < 16; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)      run_ack($urandom_range(1, 30), $urandom_range(0, 65535), $urandom_range(0, 4095));
            else if (r == 5) run_timeout();
            else if (r == 6) run_abort($urandom_range(0, 20), 1'($urandom_range(0, 1)));
            else if (r == 7) thr_step_idle();
            else             view_next();
        end

        idle(4);
        chk("thr_q_empty", thr_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
